hwpe_stream_tcdm_mux_sel_ctrl: RTL and testbench

HWPE_STREAM_TCDM_MUX_SEL_CTRL -- requirements
Module: hwpe_stream_tcdm_mux_sel_ctrl

---
 rtl/hwpe_stream_tcdm_mux_sel_ctrl_if.sv | 24 ++
 rtl/hwpe_stream_tcdm_mux_sel_ctrl.sv | 105 ++++++++++
 tb/tb_hwpe_stream_tcdm_mux_sel_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/hwpe_stream_tcdm_mux_sel_ctrl_if.sv
// rtl/hwpe_stream_tcdm_mux_sel_ctrl_if.sv - ownership requests, TCDM handshake taps and mux select outputs
interface hwpe_stream_tcdm_mux_sel_ctrl_if #(
    parameter int unsigned NB_CHAN = 2
);
    logic               want0_i;
    logic               want1_i;
    logic [NB_CHAN-1:0] tcdm_req_i;
    logic [NB_CHAN-1:0] tcdm_gnt_i;
    logic [NB_CHAN-1:0] tcdm_r_valid_i;
    logic               sel_o;
    logic               hold_o;
    logic               busy_o;
    logic               err_o;

    modport master (
        output want0_i, want1_i, tcdm_req_i, tcdm_gnt_i, tcdm_r_valid_i,
        input  sel_o, hold_o, busy_o, err_o
    );

    modport slave (
        input  want0_i, want1_i, tcdm_req_i, tcdm_gnt_i, tcdm_r_valid_i,
        output sel_o, hold_o, busy_o, err_o
    );
endinterface

// File: rtl/hwpe_stream_tcdm_mux_sel_ctrl.sv
// rtl/hwpe_stream_tcdm_mux_sel_ctrl.sv - select controller for a static TCDM mux shared by two port sets
module hwpe_stream_tcdm_mux_sel_ctrl #(
    parameter int unsigned NB_CHAN = 2,
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned QUANTUM = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             clear_i,
    hwpe_stream_tcdm_mux_sel_ctrl_if.slave   ctrl
);
    localparam int unsigned QW = $clog2(QUANTUM + 1);
    localparam logic [QW-1:0]    Q_MAX   = QW'(QUANTUM);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {OWN0, DRAIN0, OWN1, DRAIN1} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q [NB_CHAN];
    logic [CNT_W-1:0]   cnt_d [NB_CHAN];
    logic [QW-1:0]      quantum_q, quantum_d;
    logic               err_q, err_d;
    logic               drained;
    logic               busy;
    logic [NB_CHAN-1:0] grant;

    assign grant = ctrl.tcdm_req_i & ctrl.tcdm_gnt_i;

    // A counter that would wrap holds its value and flags the error instead.
    always_comb begin
        err_d   = err_q;
        drained = 1'b1;
        busy    = 1'b0;
        for (int c = 0; c < NB_CHAN; c++) begin
            cnt_d[c] = cnt_q[c];
            if (cnt_q[c] != '0) begin
                busy    = 1'b1;
                drained = 1'b0;
            end
            if (grant[c]) drained = 1'b0;
            if (grant[c] && !ctrl.tcdm_r_valid_i[c]) begin
                if (cnt_q[c] == CNT_MAX) err_d = 1'b1;
                else                     cnt_d[c] = cnt_q[c] + 1'b1;
            end else if (ctrl.tcdm_r_valid_i[c] && !grant[c]) begin
                if (cnt_q[c] == '0) err_d = 1'b1;
                else                cnt_d[c] = cnt_q[c] - 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        quantum_d = quantum_q;
        case (state_q)
            OWN0: begin
                if (ctrl.want1_i && (!ctrl.want0_i || quantum_q == Q_MAX))
                    state_d = DRAIN0;
                else if (ctrl.want1_i && quantum_q != Q_MAX)
                    quantum_d = quantum_q + 1'b1;
            end
            DRAIN0: begin
                if (drained) begin
                    state_d   = OWN1;
                    quantum_d = '0;
                end
            end
            OWN1: begin
                if (ctrl.want0_i && (!ctrl.want1_i || quantum_q == Q_MAX))
                    state_d = DRAIN1;
                else if (ctrl.want0_i && quantum_q != Q_MAX)
                    quantum_d = quantum_q + 1'b1;
            end
            default: begin
                if (drained) begin
                    state_d   = OWN0;
                    quantum_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= OWN0;
            quantum_q <= '0;
            err_q     <= 1'b0;
            for (int c = 0; c < NB_CHAN; c++) cnt_q[c] <= '0;
        end else if (clear_i) begin
            state_q   <= OWN0;
            quantum_q <= '0;
            err_q     <= 1'b0;
            for (int c = 0; c < NB_CHAN; c++) cnt_q[c] <= '0;
        end else begin
            state_q   <= state_d;
            quantum_q <= quantum_d;
            err_q     <= err_d;
            for (int c = 0; c < NB_CHAN; c++) cnt_q[c] <= cnt_d[c];
        end
    end

    assign ctrl.sel_o  = (state_q == OWN1)   || (state_q == DRAIN1);
    assign ctrl.hold_o = (state_q == DRAIN0) || (state_q == DRAIN1);
    assign ctrl.busy_o = busy;
    assign ctrl.err_o  = err_q;
endmodule

// File: tb/tb_hwpe_stream_tcdm_mux_sel_ctrl.sv
// tb/tb_hwpe_stream_tcdm_mux_sel_ctrl.sv - directed and randomized checks against a behavioural model
module tb_hwpe_stream_tcdm_mux_sel_ctrl;
    localparam int NCH   = 2;
    localparam int CMAX  = 3;
    localparam int QUANT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;

    hwpe_stream_tcdm_mux_sel_ctrl_if #(.NB_CHAN(NCH)) bus ();

    hwpe_stream_tcdm_mux_sel_ctrl #(
        .NB_CHAN (NCH),
        .CNT_W   (2),
        .QUANTUM (QUANT)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (clear),
        .ctrl    (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: who owns the mux, whether a handover is draining, outstanding counts.
    int m_cnt [NCH];
    int m_owner;
    int m_drain;
    int m_q;
    int m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) m_cnt[c] = 0;
        m_owner = 0; m_drain = 0; m_q = 0; m_err = 0;
    endtask

    task automatic model_step(input bit w0, input bit w1, input bit [1:0] rq,
                              input bit [1:0] gn, input bit [1:0] rv, input bit clr);
        int outstanding;
        int mine, other;
        if (clr) begin
            model_reset();
            return;
        end
        outstanding = 0;
        for (int c = 0; c < NCH; c++) outstanding += m_cnt[c] + ((rq[c] && gn[c]) ? 1 : 0);
        mine  = m_owner ? w1 : w0;
        other = m_owner ? w0 : w1;
        if (m_drain) begin
            if (outstanding == 0) begin
                m_owner = 1 - m_owner; m_drain = 0; m_q = 0;
            end
        end else if (other && (!mine || m_q == QUANT)) begin
            m_drain = 1;
        end else if (other) begin
            m_q = (m_q + 1 > QUANT) ? QUANT : m_q + 1;
        end
        for (int c = 0; c < NCH; c++) begin
            int delta;
            delta = ((rq[c] && gn[c]) ? 1 : 0) - (rv[c] ? 1 : 0);
            if (m_cnt[c] + delta < 0 || m_cnt[c] + delta > CMAX) m_err = 1;
            else m_cnt[c] += delta;
        end
    endtask

    task automatic compare_model();
        int any;
        any = 0;
        for (int c = 0; c < NCH; c++) if (m_cnt[c] != 0) any = 1;
        check("sel",  bus.sel_o,  m_owner);
        check("hold", bus.hold_o, m_drain);
        check("busy", bus.busy_o, any);
        check("err",  bus.err_o,  m_err);
    endtask

    task automatic apply(input bit w0, input bit w1, input bit [1:0] rq,
                         input bit [1:0] gn, input bit [1:0] rv, input bit clr);
        bus.want0_i = w0;
        bus.want1_i = w1;
        bus.tcdm_req_i = rq;
        bus.tcdm_gnt_i = gn;
        bus.tcdm_r_valid_i = rv;
        clear = clr;
        model_step(w0, w1, rq, gn, rv, clr);
        @(negedge clk);
        compare_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear = 1'b0;
        bus.want0_i = 1'b0; bus.want1_i = 1'b0;
        bus.tcdm_req_i = '0; bus.tcdm_gnt_i = '0; bus.tcdm_r_valid_i = '0;
        model_reset();
        @(negedge clk);
        compare_model();
        rst = 1'b0;
    endtask

    initial begin
        int run;
        int lens[$];
        bit [1:0] rv;

        do_reset();
        check("reset_sel", bus.sel_o, 0);
        check("reset_hold", bus.hold_o, 0);

        // Switch with two outstanding responses on channel 0.
        apply(1, 0, 2'b01, 2'b01, 2'b00, 0);
        apply(1, 0, 2'b01, 2'b01, 2'b00, 0);
        check("sw_busy", bus.busy_o, 1);
        apply(0, 1, 2'b00, 2'b00, 2'b00, 0);
        check("sw_hold1", bus.hold_o, 1);
        apply(0, 1, 2'b00, 2'b00, 2'b01, 0);
        check("sw_hold2", bus.hold_o, 1);
        apply(0, 1, 2'b00, 2'b00, 2'b01, 0);
        check("sw_hold3", bus.hold_o, 1);
        apply(0, 1, 2'b00, 2'b00, 2'b00, 0);
        check("sw_hold_end", bus.hold_o, 0);
        check("sw_sel", bus.sel_o, 1);

        // Idle switch from a one-cycle want1 pulse.
        do_reset();
        apply(0, 1, 2'b00, 2'b00, 2'b00, 0);
        check("idle_hold", bus.hold_o, 1);
        check("idle_sel0", bus.sel_o, 0);
        apply(0, 0, 2'b00, 2'b00, 2'b00, 0);
        check("idle_sel1", bus.sel_o, 1);
        check("idle_hold0", bus.hold_o, 0);

        // Quantum fairness with both sets wanting continuously.
        do_reset();
        run = 0;
        for (int i = 0; i < 90; i++) begin
            apply(1, 1, 2'b00, 2'b00, 2'b00, 0);
            if (!bus.hold_o) run++;
            else if (run > 0) begin
                lens.push_back(run);
                run = 0;
            end
        end
        check("fair_runs", (lens.size() >= 3) ? 1 : 0, 1);
        if (lens.size() >= 3) begin
            check("fair_len1", lens[1], QUANT + 1);
            check("fair_len2", lens[2], QUANT + 1);
        end

        // Underflow on channel 1 stays sticky until clear.
        do_reset();
        apply(0, 0, 2'b00, 2'b00, 2'b10, 0);
        check("uf_err", bus.err_o, 1);
        repeat (5) apply(0, 0, 2'b00, 2'b00, 2'b00, 0);
        check("uf_sticky", bus.err_o, 1);
        apply(0, 0, 2'b00, 2'b00, 2'b00, 1);
        check("uf_clear", bus.err_o, 0);

        // Overflow with 2-bit counters: four grants leave the count at 3.
        do_reset();
        repeat (4) apply(1, 0, 2'b01, 2'b01, 2'b00, 0);
        check("of_err", bus.err_o, 1);
        apply(1, 0, 2'b00, 2'b00, 2'b01, 0);
        apply(1, 0, 2'b00, 2'b00, 2'b01, 0);
        check("of_busy2", bus.busy_o, 1);
        apply(1, 0, 2'b00, 2'b00, 2'b01, 0);
        check("of_busy0", bus.busy_o, 0);

        // Asynchronous reset in the middle of a drain.
        do_reset();
        apply(1, 0, 2'b01, 2'b01, 2'b00, 0);
        apply(0, 1, 2'b00, 2'b00, 2'b00, 0);
        check("ar_hold_pre", bus.hold_o, 1);
        #2 rst = 1'b1;
        #1;
        check("ar_sel", bus.sel_o, 0);
        check("ar_hold", bus.hold_o, 0);
        check("ar_busy", bus.busy_o, 0);
        check("ar_err", bus.err_o, 0);
        model_reset();
        bus.want1_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        apply(0, 0, 2'b00, 2'b00, 2'b01, 0);
        check("ar_late_rsp", bus.err_o, 1);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NCH; c++)
                rv[c] = (m_cnt[c] > 0) ? 1'($urandom_range(0, 1))
                                       : 1'($urandom_range(0, 49) == 0);
            apply(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                  2'($urandom), 2'($urandom), rv, 1'($urandom_range(0, 99) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
